// File: rtl/gost89_pkg.sv
// Shared definitions for the gost89 ECB arbiter: block width, controller states,
// a ceil-log2 helper and the watchdog counter width.
package gost89_pkg;

    localparam int GOST_BLK_W = 64;
    localparam int GOST_WD_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE
    } arb_state_t;

    function automatic int gost_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gost89_rr_pick.sv
// Combinational round-robin picker: rotates the valid vector so the search starts
// just above the pointer, takes the lowest set bit, and maps it back to an index.
module gost89_rr_pick
    import gost89_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = gost_clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IDW-1:0]  o_index
);

    logic [IDW:0]      w_start;
    logic [NREQ-1:0]   w_rot;
    logic [IDW+1:0]    w_sum;
    logic              w_found;

    assign w_start = (IDW+1)'(i_ptr) + 1'b1;
    assign w_rot   = NREQ'({i_valid, i_valid} >> w_start);

    // The sum of start and offset stays below 2*NREQ, so one subtraction wraps it.
    always_comb begin
        w_found  = 1'b0;
        w_sum    = '0;
        o_onehot = '0;
        o_index  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = (IDW+2)'(w_start) + (IDW+2)'(k);
            end
        end
        if (w_sum >= (IDW+2)'(NREQ)) begin
            w_sum = w_sum - (IDW+2)'(NREQ);
        end
        if (w_found) begin
            o_index  = w_sum[IDW-1:0];
            o_onehot = NREQ'(1) << w_sum[IDW-1:0];
        end
    end

endmodule

// File: rtl/gost89_ecb_arb.sv
// Round-robin scheduler sharing one gost89 ECB core among NREQ requesters.
// Optional busy watchdog enabled by defining GOST89_ARB_WATCHDOG_EN.
module gost89_ecb_arb
    import gost89_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int IDW    = gost_clog2(NREQ),
    parameter int WD_MAX = 40
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ-1:0]            i_req_mode,
    input  logic [NREQ*GOST_BLK_W-1:0] i_req_data,
    output logic [NREQ-1:0]            o_req_ready,
    output logic                       o_rsp_valid,
    output logic [IDW-1:0]             o_rsp_id,
    output logic [GOST_BLK_W-1:0]      o_rsp_data,
    output logic                       o_core_load,
    output logic                       o_core_reset,
    output logic                       o_core_mode,
    output logic [GOST_BLK_W-1:0]      o_core_in,
    input  logic [GOST_BLK_W-1:0]      i_core_out,
    input  logic                       i_core_busy,
    output logic                       o_err
);

    arb_state_t              r_state;
    logic [IDW-1:0]          r_ptr;
    logic [IDW-1:0]          r_id;
    logic                    r_waitFirst;
    logic                    r_rspValid;
    logic [IDW-1:0]          r_rspId;
    logic [GOST_BLK_W-1:0]   r_rspData;
    logic                    r_coreLoad;
    logic                    r_coreMode;
    logic [GOST_BLK_W-1:0]   r_coreIn;

    logic [NREQ-1:0]         w_grant;
    logic [IDW-1:0]          w_gntIdx;
    logic                    w_xfer;
    logic [GOST_BLK_W-1:0]   w_selData;
    logic                    w_selMode;

    gost89_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_valid  (i_req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_grant),
        .o_index  (w_gntIdx)
    );

    assign o_req_ready = (r_state == IDLE && !i_reset) ? w_grant : '0;
    assign w_xfer      = |o_req_ready;

    always_comb begin
        w_selData = '0;
        w_selMode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_selData = i_req_data[i*GOST_BLK_W +: GOST_BLK_W];
                w_selMode = i_req_mode[i];
            end
        end
    end

`ifdef GOST89_ARB_WATCHDOG_EN
    logic [GOST_WD_W-1:0] r_wdCnt;
    logic                 r_wdPulse;
    logic                 r_err;

    assign o_core_reset = i_reset | r_wdPulse;
    assign o_err        = r_err;
`else
    assign o_core_reset = i_reset;
    assign o_err        = 1'b0;
`endif

    // The first WAIT cycle is skipped because the core raises busy only after it samples load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_waitFirst <= 1'b0;
            r_rspValid  <= 1'b0;
            r_rspId     <= '0;
            r_rspData   <= '0;
            r_coreLoad  <= 1'b0;
            r_coreMode  <= 1'b0;
            r_coreIn    <= '0;
`ifdef GOST89_ARB_WATCHDOG_EN
            r_wdCnt     <= '0;
            r_wdPulse   <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_rspValid <= 1'b0;
            r_coreLoad <= 1'b0;
`ifdef GOST89_ARB_WATCHDOG_EN
            r_wdPulse  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_coreIn   <= w_selData;
                        r_coreMode <= w_selMode;
                        r_id       <= w_gntIdx;
                        r_ptr      <= w_gntIdx;
                        r_coreLoad <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_waitFirst <= 1'b1;
`ifdef GOST89_ARB_WATCHDOG_EN
                    r_wdCnt     <= '0;
`endif
                    r_state     <= WAIT;
                end
                WAIT: begin
                    r_waitFirst <= 1'b0;
                    if (!r_waitFirst && !i_core_busy) begin
                        r_rspData  <= i_core_out;
                        r_rspId    <= r_id;
                        r_rspValid <= 1'b1;
                        r_state    <= DONE;
                    end
`ifdef GOST89_ARB_WATCHDOG_EN
                    else if (i_core_busy) begin
                        if (r_wdCnt == GOST_WD_W'(WD_MAX - 1)) begin
                            r_wdPulse  <= 1'b1;
                            r_err      <= 1'b1;
                            r_rspData  <= '0;
                            r_rspId    <= r_id;
                            r_rspValid <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_wdCnt <= r_wdCnt + 1'b1;
                        end
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_rsp_valid = r_rspValid;
    assign o_rsp_id    = r_rspId;
    assign o_rsp_data  = r_rspData;
    assign o_core_load = r_coreLoad;
    assign o_core_mode = r_coreMode;
    assign o_core_in   = r_coreIn;

endmodule
